// File: rtl/ldmstm_uop_seq_pkg.sv
// Shared types and encodings for the LDM/STM micro-op sequencer.
// Holds the FSM state type, opcode constants and micro-op encoders.
package leg_uop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } uop_state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;
    localparam logic [3:0]  OP_ADD    = 4'b0100;
    localparam logic [3:0]  OP_SUB    = 4'b0010;

    localparam int unsigned P_BIT = 24;
    localparam int unsigned U_BIT = 23;
    localparam int unsigned W_BIT = 21;
    localparam int unsigned L_BIT = 20;

    // Single-register LDR/STR with pre-indexed immediate offset and no writeback.
    function automatic logic [31:0] memUop(
        input logic [3:0]  cond,
        input logic        u,
        input logic        l,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [11:0] imm
    );
        return {cond, 3'b010, 1'b1, u, 2'b00, l, rn, rd, imm};
    endfunction

    function automatic logic [31:0] wbUop(
        input logic [3:0] cond,
        input logic       u,
        input logic [3:0] rn,
        input logic [4:0] n
    );
        return {cond, 3'b001, (u ? OP_ADD : OP_SUB), 1'b0, rn, rn, 4'h0, {1'b0, n, 2'b00}};
    endfunction

endpackage

// File: rtl/ldmstm_uop_seq_lsb.sv
// Lowest-set-bit index and population count of a 16-bit register mask.
module lsb_index16 (
    input  logic [15:0] mask,
    output logic [3:0]  lowIdx,
    output logic [4:0]  count
);

    logic found;

    always_comb begin
        lowIdx = '0;
        count  = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mask[i]) begin
                count = count + 5'd1;
                if (!found) begin
                    lowIdx = 4'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ldmstm_uop_seq.sv
// Decode-stage sequencer that cracks LDM/STM into single-register LDR/STR
// micro-ops plus an optional base-writeback ADD/SUB.
module ldmstm_uop_seq
    import leg_uop_pkg::*;
#(
    parameter int          INSTR_W   = 32,
    parameter int          NREGS     = 16,
    parameter logic [31:0] NOP_INSTR = leg_uop_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] InstrD,
    input  logic               StalluOp,
    input  logic               FlushD,
    output logic [INSTR_W-1:0] uOpInstrD,
    output logic               uOpStallD,
    output logic               uOpActiveD
);

    uop_state_t state, stateN;

    logic [NREGS-1:0] mask;
    logic [4:0]       k, n;
    logic [3:0]       cond, rn;
    logic             pBit, uBit, lBit, wbEn;

    logic             isLdm;
    logic [NREGS-1:0] listD, srcMask, srcCleared;
    logic [3:0]       lowIdx;
    logic [4:0]       cnt;

    logic [3:0]       fCond, fRn;
    logic             fP, fU, fL, fWb;
    logic [4:0]       fK, fN;
    logic [9:0]       off, offMag;
    logic [31:0]      memOp, wbOp;
    logic             lastMem, load, advance;

    assign isLdm      = (InstrD[27:25] == 3'b100);
    assign listD      = InstrD[15:0];
    assign srcMask    = (state == IDLE) ? listD : mask;
    assign srcCleared = srcMask & (srcMask - 16'd1);

    lsb_index16 uLsb (
        .mask   (srcMask),
        .lowIdx (lowIdx),
        .count  (cnt)
    );

    // In IDLE the first micro-op is formatted straight from InstrD; later ones use latched fields.
    always_comb begin
        if (state == IDLE) begin
            fCond = InstrD[31:28];
            fP    = InstrD[P_BIT];
            fU    = InstrD[U_BIT];
            fL    = InstrD[L_BIT];
            fRn   = InstrD[19:16];
            fK    = '0;
            fN    = cnt;
            fWb   = InstrD[W_BIT] && !(InstrD[L_BIT] && listD[InstrD[19:16]]);
        end else begin
            fCond = cond;
            fP    = pBit;
            fU    = uBit;
            fL    = lBit;
            fRn   = rn;
            fK    = k;
            fN    = n;
            fWb   = wbEn;
        end
    end

    // IA/IB/DA/DB collapse to 4k, +4 when P==U, minus 4N when decrementing.
    always_comb begin
        off    = {3'b000, fK, 2'b00} + ((fP == fU) ? 10'd4 : 10'd0)
               - (fU ? 10'd0 : {3'b000, fN, 2'b00});
        offMag = off[9] ? (10'd0 - off) : off;
        memOp  = memUop(fCond, ~off[9], fL, fRn, lowIdx, {2'b00, offMag});
        wbOp   = wbUop(fCond, fU, fRn, fN);
    end

    assign lastMem = (fK == (fN - 5'd1));

    always_comb begin
        uOpInstrD  = InstrD;
        uOpStallD  = 1'b0;
        uOpActiveD = 1'b0;
        stateN     = state;
        load       = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (isLdm) begin
                    uOpActiveD = 1'b1;
                    if (cnt == 5'd0) begin
                        uOpInstrD = NOP_INSTR;
                    end else begin
                        uOpInstrD = memOp;
                        load      = 1'b1;
                        if (cnt >= 5'd2) begin
                            stateN    = MEM;
                            uOpStallD = 1'b1;
                        end else if (fWb) begin
                            stateN    = WB;
                            uOpStallD = 1'b1;
                        end
                    end
                end
            end
            MEM: begin
                uOpActiveD = 1'b1;
                uOpInstrD  = memOp;
                advance    = 1'b1;
                if (!lastMem) begin
                    uOpStallD = 1'b1;
                end else if (fWb) begin
                    uOpStallD = 1'b1;
                    stateN    = WB;
                end else begin
                    stateN = IDLE;
                end
            end
            WB: begin
                uOpActiveD = 1'b1;
                uOpInstrD  = wbOp;
                stateN     = IDLE;
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || FlushD) begin
            state <= IDLE;
            mask  <= '0;
            k     <= '0;
            n     <= '0;
            cond  <= '0;
            rn    <= '0;
            pBit  <= 1'b0;
            uBit  <= 1'b0;
            lBit  <= 1'b0;
            wbEn  <= 1'b0;
        end else if (!StalluOp) begin
            state <= stateN;
            if (load) begin
                mask <= srcCleared;
                k    <= 5'd1;
                n    <= cnt;
                cond <= fCond;
                rn   <= fRn;
                pBit <= fP;
                uBit <= fU;
                lBit <= fL;
                wbEn <= fWb;
            end else if (advance) begin
                mask <= srcCleared;
                k    <= k + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_ldmstm_uop_seq.sv
// Randomized and directed bench for ldmstm_uop_seq against an architectural model
// that expands LDM/STM into its list of micro-ops.
module tb_ldmstm_uop_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        StalluOp;
    logic        FlushD;
    logic [31:0] uOpInstrD;
    logic        uOpStallD;
    logic        uOpActiveD;

    int checks = 0;
    int errors = 0;

    logic [31:0] expQ[$];
    logic        expAct;

    ldmstm_uop_seq dut (
        .clk        (clk),
        .reset      (reset),
        .InstrD     (InstrD),
        .StalluOp   (StalluOp),
        .FlushD     (FlushD),
        .uOpInstrD  (uOpInstrD),
        .uOpStallD  (uOpStallD),
        .uOpActiveD (uOpActiveD)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expand one instruction into the sequence the decoder should see.
    function automatic void buildExp(input logic [31:0] ins);
        int          nr, k, off, mag;
        logic [3:0]  c, rn;
        logic        p, u, w, l, usgn;
        logic [15:0] lst;
        expQ.delete();
        if (ins[27:25] != 3'b100) begin
            expQ.push_back(ins);
            expAct = 1'b0;
            return;
        end
        expAct = 1'b1;
        c = ins[31:28]; p = ins[24]; u = ins[23]; w = ins[21]; l = ins[20];
        rn = ins[19:16]; lst = ins[15:0];
        nr = $countones(lst);
        if (nr == 0) begin
            expQ.push_back(32'hE1A00000);
            return;
        end
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (lst[r]) begin
                case ({p, u})
                    2'b01:   off = 4 * k;
                    2'b11:   off = 4 * (k + 1);
                    2'b00:   off = 4 * k - 4 * (nr - 1);
                    default: off = 4 * k - 4 * nr;
                endcase
                usgn = (off >= 0);
                mag  = (off < 0) ? -off : off;
                expQ.push_back({c, 3'b010, 1'b1, usgn, 2'b00, l, rn, 4'(r), 12'(mag)});
                k++;
            end
        end
        if (w && !(l && lst[rn]))
            expQ.push_back({c, 3'b001, (u ? 4'b0100 : 4'b0010), 1'b0, rn, rn, 4'h0, 8'(4 * nr)});
    endfunction

    // Drive ins and walk expQ; stallPat forces StalluOp per cycle, flushAt aborts at that micro-op.
    task automatic runSeq(input logic [31:0] ins, input int stallPct, input logic [31:0] stallPat,
                          input int flushAt, input string tag);
        int   i, cyc, sz;
        logic expStall, flushed;
        InstrD  = ins;
        i       = 0;
        cyc     = 0;
        sz      = expQ.size();
        flushed = 1'b0;
        while (i < sz && cyc < 200 && !flushed) begin
            StalluOp = (cyc < 32 && stallPat[cyc]) || ($urandom_range(99) < stallPct);
            FlushD   = (i == flushAt);
            @(negedge clk);
            expStall = (i < sz - 1);
            checks++;
            if (uOpInstrD !== expQ[i] || uOpStallD !== expStall || uOpActiveD !== expAct) begin
                errors++;
                $display("FAIL %s ins=%h uop%0d cyc%0d: got instr=%h stall=%b active=%b, want instr=%h stall=%b active=%b",
                         tag, ins, i, cyc, uOpInstrD, uOpStallD, uOpActiveD, expQ[i], expStall, expAct);
            end
            @(posedge clk);
            #1;
            if (FlushD) flushed = 1'b1;
            else if (!StalluOp) i++;
            cyc++;
        end
        if (!flushed && i < sz) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: reached uop %0d of %0d", tag, i, sz);
        end
        StalluOp = 1'b0;
        FlushD   = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        StalluOp = 1'b0;
        FlushD   = 1'b0;
        InstrD   = 32'hE5912000;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (uOpInstrD !== 32'hE5912000 || uOpStallD !== 1'b0 || uOpActiveD !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%b want E5912000/0/0", uOpInstrD, uOpStallD, uOpActiveD);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_directed;
        expAct = 1'b1;
        expQ = '{32'hE5901000, 32'hE5903004, 32'hE2800008};
        runSeq(32'hE8B0000A, 0, 32'h0, -1, "ldmia_wb");
        expQ = '{32'hE50D4008, 32'hE50DE004, 32'hE24DD008};
        runSeq(32'hE92D4010, 0, 32'h0, -1, "stmdb_sp");
        expQ = '{32'hE5922000};
        runSeq(32'hE8B20004, 0, 32'h0, -1, "ldm_rn_in_list");
        expQ = '{32'hE1A00000};
        runSeq(32'hE8900000, 0, 32'h0, -1, "empty_list");
        expAct = 1'b0;
        expQ = '{32'hE5912000};
        runSeq(32'hE5912000, 0, 32'h0, -1, "passthrough");
    endtask

    task automatic test_stall;
        expAct = 1'b1;
        expQ = '{32'hE5901000, 32'hE5902004, 32'hE5903008};
        runSeq(32'hE890000E, 0, 32'h6, -1, "stall_hold");
    endtask

    task automatic test_flush;
        buildExp(32'hE890001E);
        runSeq(32'hE890001E, 0, 32'h0, 1, "flush_mid");
        expAct = 1'b0;
        expQ = '{32'hE1A01002};
        runSeq(32'hE1A01002, 0, 32'h0, -1, "after_flush");
    endtask

    task automatic test_reset_mid;
        buildExp(32'hE890001E);
        InstrD = 32'hE890001E;
        @(negedge clk);
        checks++;
        if (uOpInstrD !== expQ[0] || uOpStallD !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_first: got %h/%b want %h/1", uOpInstrD, uOpStallD, expQ[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        InstrD = 32'hE5912000;
        @(negedge clk);
        checks++;
        if (uOpInstrD !== 32'hE5912000 || uOpStallD !== 1'b0 || uOpActiveD !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: got %h/%b/%b want E5912000/0/0", uOpInstrD, uOpStallD, uOpActiveD);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [31:0] ins;
        int          sel, fl;
        for (int t = 0; t < 80; t++) begin
            ins = $urandom();
            if ($urandom_range(3) != 0) begin
                ins[27:25] = 3'b100;
                sel = $urandom_range(7);
                if (sel == 0)      ins[15:0] = 16'h0;
                else if (sel <= 2) ins[15:0] = 16'h1 << ins[19:16];
                else if (sel == 3) ins[15:0] = 16'h1 << $urandom_range(15);
            end else if (ins[27:25] == 3'b100) begin
                ins[25] = 1'b1;
            end
            buildExp(ins);
            fl = ($urandom_range(9) == 0) ? $urandom_range(expQ.size() - 1) : -1;
            runSeq(ins, 25, 32'h0, fl, "random");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stall;
        test_flush;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
